ryu_controller: RTL and testbench

RYU_CONTROLLER -- requirements
Module: ryu_controller

---
 rtl/ryu_pkg.sv | 32 +++
 rtl/ryu_vsync_edge.sv | 25 ++
 rtl/ryu_controller.sv | 173 +++++++++++++++++
 tb/tb_ryu_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ryu_pkg.sv
// Shared types and constants for the Ryu sprite controller.
// The optional feature macro RYU_AIR_CONTROL_EN is consumed by ryu_controller.
package ryu_pkg;

    localparam logic [2:0] SPR_STAND = 3'd0;
    localparam logic [2:0] SPR_PUNCH = 3'd1;
    localparam logic [2:0] SPR_JUMP  = 3'd2;

    typedef enum logic [1:0] {
        ST_STAND = 2'd0,
        ST_PUNCH = 2'd1,
        ST_JUMP  = 2'd2
    } ryu_state_e;

    // Signed 11-bit so position arithmetic can go below zero before clamping.
    typedef logic signed [10:0] pos_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_e;

    function automatic dir_e key_dir(input logic left, input logic right);
        dir_e d;
        d = DIR_NONE;
        if (left && !right) d = DIR_LEFT;
        else if (right && !left) d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/ryu_vsync_edge.sv
// Frame tick generator: one-cycle pulse on each falling edge of vsync,
// held off for the first cycle after reset release.
module vsync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vsync_i,
    output logic frame_tick_o
);

    logic vsync_q;
    logic armed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vsync_q <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            armed_q <= 1'b1;
        end
    end

    assign frame_tick_o = armed_q & vsync_q & ~vsync_i;

endmodule

// File: rtl/ryu_controller.sv
// Ryu character controller: walk, punch and jump, advancing once per video frame.
// Define RYU_AIR_CONTROL_EN for live left/right steering while airborne.
module ryu_controller
    import ryu_pkg::*;
#(
    parameter logic        [9:0] X_START      = 10'd100,
    parameter logic        [9:0] X_MIN        = 10'd0,
    parameter logic        [9:0] X_MAX        = 10'd576,
    parameter logic        [9:0] GROUND_Y     = 10'd300,
    parameter logic        [3:0] WALK_STEP    = 4'd3,
    parameter logic        [4:0] PUNCH_FRAMES = 5'd12,
    parameter logic signed [7:0] JUMP_V0      = 8'sd12,
    parameter logic signed [7:0] GRAVITY      = 8'sd1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_punch,
    input  logic       key_jump,
    output logic [9:0] RyuX,
    output logic [9:0] RyuY,
    output logic [2:0] sprite,
    output ryu_state_e dbg_state_o
);

    localparam pos_t STEP_S   = pos_t'({7'd0, WALK_STEP});
    localparam pos_t X_MIN_S  = pos_t'({1'b0, X_MIN});
    localparam pos_t X_MAX_S  = pos_t'({1'b0, X_MAX});
    localparam pos_t GROUND_S = pos_t'({1'b0, GROUND_Y});
    localparam logic [4:0] PUNCH_LAST = 5'(PUNCH_FRAMES - 5'd1);

    logic frame_tick;

    vsync_edge u_vsync_edge (
        .clk_i        (vga_clk),
        .rst_ni       (reset_n),
        .vsync_i      (vsync),
        .frame_tick_o (frame_tick)
    );

    ryu_state_e        state_q, state_d;
    logic        [9:0] x_q, x_d;
    logic        [9:0] y_q, y_d;
    logic signed [7:0] vel_q, vel_d;
    logic        [4:0] cnt_q, cnt_d;
    logic              punch_prev_q, punch_prev_d;
    logic        [2:0] sprite_q, sprite_d;
`ifndef RYU_AIR_CONTROL_EN
    dir_e              dir_q, dir_d;
`endif

    dir_e              move_dir;
    logic              jump_step;
    logic signed [7:0] step_vel;
    pos_t              x_calc;
    pos_t              y_calc;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q      <= ST_STAND;
            x_q          <= X_START;
            y_q          <= GROUND_Y;
            vel_q        <= '0;
            cnt_q        <= '0;
            punch_prev_q <= 1'b0;
            sprite_q     <= SPR_STAND;
`ifndef RYU_AIR_CONTROL_EN
            dir_q        <= DIR_NONE;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            cnt_q        <= cnt_d;
            punch_prev_q <= punch_prev_d;
            sprite_q     <= sprite_d;
`ifndef RYU_AIR_CONTROL_EN
            dir_q        <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vel_d        = vel_q;
        cnt_d        = cnt_q;
        punch_prev_d = punch_prev_q;
`ifndef RYU_AIR_CONTROL_EN
        dir_d        = dir_q;
`endif
        move_dir     = DIR_NONE;
        jump_step    = 1'b0;
        step_vel     = vel_q;
        x_calc       = '0;
        y_calc       = '0;

        if (frame_tick) begin
            punch_prev_d = key_punch;
            unique case (state_q)
                ST_STAND: begin
                    move_dir = key_dir(key_left, key_right);
                    if (key_jump) begin
                        jump_step = 1'b1;
                        step_vel  = JUMP_V0;
`ifndef RYU_AIR_CONTROL_EN
                        dir_d     = move_dir;
`endif
                    end else if (key_punch && !punch_prev_q) begin
                        state_d = ST_PUNCH;
                        cnt_d   = '0;
                    end
                end
                ST_PUNCH: begin
                    if (cnt_q == PUNCH_LAST) begin
                        state_d = ST_STAND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_JUMP: begin
                    jump_step = 1'b1;
                    step_vel  = vel_q;
`ifdef RYU_AIR_CONTROL_EN
                    move_dir  = key_dir(key_left, key_right);
`else
                    move_dir  = dir_q;
`endif
                end
                default: state_d = ST_STAND;
            endcase

            // The takeoff tick already applies the first upward step.
            if (jump_step) begin
                y_calc = $signed({1'b0, y_q}) - $signed({{3{step_vel[7]}}, step_vel});
                if (y_calc >= GROUND_S) begin
                    y_d     = GROUND_Y;
                    vel_d   = '0;
                    state_d = ST_STAND;
                end else begin
                    y_d     = (y_calc < 0) ? 10'd0 : y_calc[9:0];
                    vel_d   = step_vel - GRAVITY;
                    state_d = ST_JUMP;
                end
            end

            if (move_dir != DIR_NONE) begin
                if (move_dir == DIR_LEFT) x_calc = $signed({1'b0, x_q}) - STEP_S;
                else                      x_calc = $signed({1'b0, x_q}) + STEP_S;
                if (x_calc < X_MIN_S)      x_d = X_MIN;
                else if (x_calc > X_MAX_S) x_d = X_MAX;
                else                       x_d = x_calc[9:0];
            end
        end

        unique case (state_d)
            ST_PUNCH: sprite_d = SPR_PUNCH;
            ST_JUMP:  sprite_d = SPR_JUMP;
            default:  sprite_d = SPR_STAND;
        endcase
    end

    assign RyuX        = x_q;
    assign RyuY        = y_q;
    assign sprite      = sprite_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ryu_controller.sv
// Self-checking bench for ryu_controller: directed vectors, corner sequences
// and randomized frames compared against a frame-level behavioural model.
module tb_ryu_controller;

  localparam int XS  = 100;
  localparam int XLO = 0;
  localparam int XHI = 576;
  localparam int GND = 300;
  localparam int STP = 3;
  localparam int PF  = 12;
  localparam int V0  = 12;
  localparam int GR  = 1;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic vsync = 1'b1;
  logic key_left = 1'b0, key_right = 1'b0, key_punch = 1'b0, key_jump = 1'b0;
  logic [9:0] RyuX, RyuY;
  logic [2:0] sprite;
  ryu_pkg::ryu_state_e dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  ryu_controller dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_punch   (key_punch),
    .key_jump    (key_jump),
    .RyuX        (RyuX),
    .RyuY        (RyuY),
    .sprite      (sprite),
    .dbg_state_o (dbg_state)
  );

  always #5 vga_clk = ~vga_clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode: 0 standing, 1 punching, 2 airborne. Jump height uses the closed form
  // of constant-acceleration motion measured in frames since takeoff.
  int m_x, m_y, m_spr, m_jn, m_pn, m_dir, m_pprev;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int jump_y(input int n);
    return GND - (n * V0 - (GR * n * (n - 1)) / 2);
  endfunction

  task automatic model_reset();
    m_x = XS; m_y = GND; m_spr = 0; m_jn = 0; m_pn = 0; m_dir = 0; m_pprev = 0;
  endtask

  task automatic model_tick(input logic l, input logic r, input logic p, input logic j);
    int d;
    int y;
    d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    case (m_spr)
      0: begin
        m_x = clampi(m_x + STP * d, XLO, XHI);
        if (j) begin
          m_dir = d;
          m_jn = 1;
          y = jump_y(1);
          if (y >= GND) m_y = GND;
          else begin m_y = (y < 0) ? 0 : y; m_spr = 2; end
        end else if (p && !m_pprev) begin
          m_spr = 1;
          m_pn = 1;
        end
      end
      1: begin
        if (m_pn == PF) m_spr = 0;
        else m_pn++;
      end
      default: begin
`ifdef RYU_AIR_CONTROL_EN
        m_x = clampi(m_x + STP * d, XLO, XHI);
`else
        m_x = clampi(m_x + STP * m_dir, XLO, XHI);
`endif
        m_jn++;
        y = jump_y(m_jn);
        if (y >= GND) begin m_y = GND; m_spr = 0; end
        else m_y = (y < 0) ? 0 : y;
      end
    endcase
    m_pprev = p;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"}, int'(RyuX), m_x);
    check({tag, ".y"}, int'(RyuY), m_y);
    check({tag, ".spr"}, int'(sprite), m_spr);
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    @(negedge vga_clk);
    reset_n = 1'b0; vsync = 1'b1;
    key_left = 0; key_right = 0; key_punch = 0; key_jump = 0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One frame: vsync falls for a cycle with keys stable; outputs are sampled
  // on the falling clock edge after the tick edge.
  task automatic do_tick(input logic l, input logic r, input logic p, input logic j);
    @(negedge vga_clk);
    key_left = l; key_right = r; key_punch = p; key_jump = j;
    vsync = 1'b0;
    @(negedge vga_clk);
    vsync = 1'b1;
  endtask

  typedef struct {
    logic l, r, p, j;
    int ex, ey, es;
  } vec_t;

  vec_t vt[8];

  initial begin
    int ones;
    int lo_y;

    // ---- reset state and idle frames ----
    apply_reset();
    @(negedge vga_clk);
    check("rst.x", int'(RyuX), XS);
    check("rst.y", int'(RyuY), GND);
    check("rst.spr", int'(sprite), 0);
    check("rst.state", int'(dbg_state), int'(ryu_pkg::ST_STAND));
    for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0);
    check("idle3.x", int'(RyuX), 100);
    check("idle3.y", int'(RyuY), 300);
    check("idle3.spr", int'(sprite), 0);

    // ---- table of directed frames from reset ----
    vt[0] = '{0, 0, 0, 0, 100, 300, 0};
    vt[1] = '{0, 1, 0, 0, 103, 300, 0};
    vt[2] = '{1, 0, 0, 0, 100, 300, 0};
    vt[3] = '{1, 1, 0, 0, 100, 300, 0};
    vt[4] = '{0, 1, 1, 0, 103, 300, 1};
    vt[5] = '{0, 1, 0, 0, 103, 300, 1};
    vt[6] = '{1, 0, 1, 1, 103, 300, 1};
    vt[7] = '{0, 0, 0, 0, 103, 300, 1};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_tick(vt[i].l, vt[i].r, vt[i].p, vt[i].j);
      check($sformatf("vec%0d.x", i), int'(RyuX), vt[i].ex);
      check($sformatf("vec%0d.y", i), int'(RyuY), vt[i].ey);
      check($sformatf("vec%0d.spr", i), int'(sprite), vt[i].es);
    end

    // ---- walking and horizontal clamps ----
    apply_reset();
    for (int i = 0; i < 10; i++) do_tick(0, 1, 0, 0);
    check("walk_r10.x", int'(RyuX), 130);
    apply_reset();
    for (int i = 0; i < 33; i++) do_tick(1, 0, 0, 0);
    check("walk_l33.x", int'(RyuX), 1);
    do_tick(1, 0, 0, 0);
    check("clamp_lo.x", int'(RyuX), 0);
    do_tick(1, 0, 0, 0);
    check("clamp_lo_hold.x", int'(RyuX), 0);
    for (int i = 0; i < 200; i++) do_tick(0, 1, 0, 0);
    check("clamp_hi.x", int'(RyuX), 576);

    // ---- held punch fires once, for exactly PF frames ----
    apply_reset();
    ones = 0;
    for (int i = 1; i <= 40; i++) begin
      do_tick(0, 0, 1, 0);
      if (sprite == 3'd1) ones++;
      if (i == 12) check("punch_last.spr", int'(sprite), 1);
      if (i == 13) check("punch_end.spr", int'(sprite), 0);
    end
    check("punch_frames", ones, 12);
    check("punch_held.spr", int'(sprite), 0);
    do_tick(0, 0, 0, 0);
    do_tick(0, 0, 1, 0);
    check("punch_again.spr", int'(sprite), 1);

    // ---- single jump trajectory ----
    apply_reset();
    lo_y = 1000;
    for (int n = 1; n <= 25; n++) begin
      do_tick(0, 0, 0, n == 1);
      if (int'(RyuY) < lo_y) lo_y = int'(RyuY);
      if (n < 25) begin
        check($sformatf("jump%0d.y", n), int'(RyuY), jump_y(n));
        check($sformatf("jump%0d.spr", n), int'(sprite), 2);
      end
    end
    check("jump_land.y", int'(RyuY), 300);
    check("jump_land.spr", int'(sprite), 0);
    check("jump_min.y", lo_y, 222);

    // ---- jump beats punch; reset mid-jump ----
    apply_reset();
    do_tick(0, 0, 1, 1);
    check("jump_vs_punch.spr", int'(sprite), 2);
    for (int n = 2; n <= 4; n++) do_tick(0, 0, 1, 0);
    check("jump4.y", int'(RyuY), jump_y(4));
    @(negedge vga_clk);
    reset_n = 1'b0; vsync = 1'b0;
    @(negedge vga_clk);
    check("midjump_rst.y", int'(RyuY), 300);
    check("midjump_rst.spr", int'(sprite), 0);
    check("midjump_rst.x", int'(RyuX), 100);
    vsync = 1'b1;
    apply_reset();

    // ---- direction during a jump ----
    apply_reset();
    for (int n = 1; n <= 25; n++) begin
      do_tick(0, n == 1, 0, n == 1);
`ifdef RYU_AIR_CONTROL_EN
      check($sformatf("air%0d.x", n), int'(RyuX), 103);
`else
      check($sformatf("air%0d.x", n), int'(RyuX), 100 + 3 * n);
`endif
    end
    check("air_land.spr", int'(sprite), 0);
    do_tick(0, 0, 0, 0);
`ifdef RYU_AIR_CONTROL_EN
    check("air_after.x", int'(RyuX), 103);
`else
    check("air_after.x", int'(RyuX), 175);
`endif

    // ---- no tick on first cycle after reset release ----
    @(negedge vga_clk);
    reset_n = 1'b0; vsync = 1'b1; key_jump = 1'b1;
    @(negedge vga_clk);
    vsync = 1'b0;
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    @(negedge vga_clk);
    check("release_notick.spr", int'(sprite), 0);
    check("release_notick.y", int'(RyuY), 300);
    key_jump = 1'b0; vsync = 1'b1;
    apply_reset();

    // ---- randomized frames against the model ----
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      logic l, r, p, j;
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
        @(negedge vga_clk);
        check_model($sformatf("rnd%0d_rst", i));
      end
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 24) == 0);
      do_tick(l, r, p, j);
      model_tick(l, r, p, j);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
